// File: rtl/f1_start_ctrl.sv
// Start sequencer for the F1 lights FSM: paces eight light steps, holds for a
// pseudo-random delay, issues lights-out and times the reaction. Optional jump-start detection: F1_JUMP_START_EN.
module f1_start_ctrl #(
    parameter int TICK_N     = 1000,
    parameter int STEP_TICKS = 1000,
    parameter int DELAY_MIN  = 200,
    parameter int RT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            react,
    output logic            en,
    output logic            busy,
    output logic [RT_W-1:0] rt,
    output logic            rt_valid,
    output logic            jump_start
);
    localparam int PW = (TICK_N > 2) ? $clog2(TICK_N) : 1;
    localparam int SW = $clog2(STEP_TICKS + 1);
    localparam int DW = $clog2(DELAY_MIN + 128);

    typedef enum logic [2:0] {IDLE, ARM, HOLD, TIME, DONE} state_t;

    state_t          state_q, state_d;
    logic            trig_q;
    logic [6:0]      lfsr_q, lfsr_d;
    logic [PW-1:0]   psc_q, psc_d;
    logic [SW-1:0]   step_q, step_d;
    logic [2:0]      lights_q, lights_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic [RT_W-1:0] rt_q, rt_d;
    logic            rt_valid_q, rt_valid_d;
    logic            jump_q, jump_d;
    logic            start, tick;

    assign start = trigger & ~trig_q;
    assign tick  = (psc_q == PW'(TICK_N - 1));

    always_comb begin
        state_d    = state_q;
        lfsr_d     = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        psc_d      = '0;
        step_d     = step_q;
        lights_d   = lights_q;
        delay_d    = delay_q;
        dcnt_d     = dcnt_q;
        en_d       = 1'b0;
        rt_d       = rt_q;
        rt_valid_d = rt_valid_q;
        jump_d     = jump_q;
        if (state_q == ARM || state_q == HOLD || state_q == TIME)
            psc_d = tick ? '0 : psc_q + 1'b1;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = ARM;
                    psc_d      = '0;
                    step_d     = '0;
                    lights_d   = '0;
                    rt_valid_d = 1'b0;
                    jump_d     = 1'b0;
                end
            end
            ARM: begin
                if (tick) begin
                    if (step_q == SW'(STEP_TICKS - 1)) begin
                        step_d   = '0;
                        en_d     = 1'b1;
                        lights_d = lights_q + 1'b1;
                        if (lights_q == 3'd7) begin
                            // lfsr_d is the value on show during the 8th en cycle
                            delay_d = DW'(DELAY_MIN) + DW'(lfsr_d);
                            dcnt_d  = '0;
                            psc_d   = '0;
                            state_d = HOLD;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            HOLD: begin
`ifdef F1_JUMP_START_EN
                if (react) begin
                    en_d       = 1'b1;
                    jump_d     = 1'b1;
                    rt_d       = '0;
                    rt_valid_d = 1'b1;
                    psc_d      = '0;
                    state_d    = DONE;
                end else
`endif
                if (tick) begin
                    if (DW'(dcnt_q + 1'b1) == delay_q) begin
                        en_d    = 1'b1;
                        rt_d    = '0;
                        psc_d   = '0;
                        state_d = TIME;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            TIME: begin
                // react is blind during the lights-out pulse itself
                if (react && !en_q) begin
                    rt_valid_d = 1'b1;
                    psc_d      = '0;
                    state_d    = DONE;
                end else if (tick && rt_q != '1) begin
                    rt_d = rt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ARM) || (state_d == HOLD) || (state_d == TIME);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            lfsr_q     <= 7'h01;
            psc_q      <= '0;
            step_q     <= '0;
            lights_q   <= '0;
            delay_q    <= '0;
            dcnt_q     <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            rt_q       <= '0;
            rt_valid_q <= 1'b0;
            jump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trigger;
            lfsr_q     <= lfsr_d;
            psc_q      <= psc_d;
            step_q     <= step_d;
            lights_q   <= lights_d;
            delay_q    <= delay_d;
            dcnt_q     <= dcnt_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            rt_q       <= rt_d;
            rt_valid_q <= rt_valid_d;
            jump_q     <= jump_d;
        end
    end

    assign en         = en_q;
    assign busy       = busy_q;
    assign rt         = rt_q;
    assign rt_valid   = rt_valid_q;
    assign jump_start = jump_q;
endmodule

// File: tb/tb_f1_start_ctrl.sv
// Scoreboard bench for f1_start_ctrl with small timing parameters.
module tb_f1_start_ctrl;
    localparam int TICK_N = 4, STEP_TICKS = 2, DELAY_MIN = 3, RT_W = 4;

    logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, react = 1'b0;
    logic en, busy, rt_valid, jump_start;
    logic [RT_W-1:0] rt;

    f1_start_ctrl #(.TICK_N(TICK_N), .STEP_TICKS(STEP_TICKS), .DELAY_MIN(DELAY_MIN), .RT_W(RT_W)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .react(react),
        .en(en), .busy(busy), .rt(rt), .rt_valid(rt_valid), .jump_start(jump_start));

    always #5 clk = ~clk;

    // kind 0: en at absolute cycle; kind 1: en after LFSR hold gap; kind 2: result
    typedef struct {
        int kind;
        int cyc;
        int rt;
        bit jmp;
        bit chk_busy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0, errors = 0;
    logic [6:0] m_lfsr;
    int   last_en_cyc = 0;
    int   last_l = 0;
    bit   rv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst)
        if (rst) m_lfsr <= 7'h01;
        else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int kind, input int c, input int r, input bit j, input bit b);
        exp_t e;
        e.kind = kind; e.cyc = c; e.rt = r; e.jmp = j; e.chk_busy = b;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        int   want;
        if (rst) begin
            rv_prev = 1'b0;
        end else begin
            if (en) begin
                if (q.size() == 0) begin
                    chk("unexpected_en", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (e.kind == 0) begin
                        chk("en_cycle", cyc, e.cyc);
                    end else if (e.kind == 1) begin
                        chk("hold_lfsr_nonzero", int'(last_l != 0), 1);
                        want = last_en_cyc + (DELAY_MIN + last_l) * TICK_N;
                        chk("lights_out_cycle", cyc, want);
                    end else begin
                        chk("en_vs_result_order", e.kind, 0);
                    end
                    if (e.chk_busy) chk("busy_at_en", int'(busy), 1);
                end
                last_en_cyc = cyc;
                last_l      = int'(m_lfsr);
            end
            if (rt_valid && !rv_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_rt_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result_kind", e.kind, 2);
                    chk("rt_value", int'(rt), e.rt);
                    chk("jump_start", int'(jump_start), int'(e.jmp));
                end
            end
            rv_prev = rt_valid;
        end
    end

    task automatic do_trigger();
        int n;
        @(posedge clk); #1 trigger = 1'b1;
        n = cyc;
        for (int k = 1; k <= 8; k++) q.push_back(mk(0, n + 1 + 8 * k, 0, 1'b0, 1'b1));
        @(posedge clk); #1 trigger = 1'b0;
        chk("busy_on_arm", int'(busy), 1);
        chk("rt_valid_clr_on_arm", int'(rt_valid), 0);
    endtask

    task automatic wait_en(input int n);
        int seen = 0;
        int b = 0;
        while (seen < n && b < 2000) begin
            @(negedge clk);
            b++;
            if (en) seen++;
        end
        if (seen < n) begin
            checks++; errors++;
            $display("FAIL wait_en_timeout: got %0d pulses expected %0d", seen, n);
        end
    endtask

    task automatic pulse_react(input int exp_rt, input bit exp_j, input bit push);
        if (push) q.push_back(mk(2, 0, exp_rt, exp_j, 1'b0));
        react = 1'b1;
        @(posedge clk); #1 react = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rt", int'(rt), 0);
        chk("rst_rt_valid", int'(rt_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_jump", int'(jump_start), 0);
        repeat (50) @(posedge clk);
        #1 chk("idle_busy", int'(busy), 0);
        chk("idle_rt_valid", int'(rt_valid), 0);

        // Run 1: pacing, hold delay, reaction after 40 cycles
        do_trigger();
        q.push_back(mk(1, 0, 0, 1'b0, 1'b1));
        wait_en(9);
        repeat (40) @(posedge clk);
        #1 pulse_react(10, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1 chk("done_rt_hold", int'(rt), 10);
        chk("done_rt_valid_hold", int'(rt_valid), 1);
        chk("done_busy", int'(busy), 0);

        // Run 2: restart from DONE, no reaction, rt saturates
        do_trigger();
        q.push_back(mk(1, 0, 0, 1'b0, 1'b1));
        wait_en(9);
        repeat (80) @(posedge clk);
        #1 chk("rt_saturate", int'(rt), 15);
        chk("time_rt_valid", int'(rt_valid), 0);
        chk("time_busy", int'(busy), 1);
        rst = 1'b1; q.delete();
        #1 chk("rst_time_busy", int'(busy), 0);
        chk("rst_time_rt", int'(rt), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Run 3: reset mid-ARM
        do_trigger();
        wait_en(3);
        @(posedge clk); #1 rst = 1'b1; q.delete();
        @(negedge clk);
        chk("rst_arm_en", int'(en), 0);
        chk("rst_arm_busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("after_rst_idle", int'(busy), 0);

        // Run 4: fresh run after reset
        do_trigger();
        q.push_back(mk(1, 0, 0, 1'b0, 1'b1));
        wait_en(9);
        repeat (20) @(posedge clk);
        #1 pulse_react(5, 1'b0, 1'b1);
        repeat (5) @(posedge clk);

        // Run 5: react during HOLD
        do_trigger();
        wait_en(8);
        repeat (5) @(posedge clk);
`ifdef F1_JUMP_START_EN
        #1 q.push_back(mk(0, cyc + 1, 0, 1'b0, 1'b0));
        pulse_react(0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1 chk("jump_flag_hold", int'(jump_start), 1);
        chk("jump_busy", int'(busy), 0);
`else
        #1 q.push_back(mk(1, 0, 0, 1'b0, 1'b1));
        pulse_react(0, 1'b0, 1'b0);
        wait_en(1);
        repeat (8) @(posedge clk);
        #1 pulse_react(2, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1 chk("no_jump_flag", int'(jump_start), 0);
`endif
        repeat (10) @(posedge clk);
        #1 chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
